// File: rtl/pwm8_demod_pkg.sv
// pwm8_demod_pkg
//   Shared definitions for the PWM link receive side.
//   PWM_WIDTH  level width, also used by the PWM DAC transmit side
//   state_t    demodulator FSM state encoding
package pwm8_demod_pkg;

    localparam int PWM_WIDTH = 8;

    typedef enum logic {
        ST_WARMUP  = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

endpackage

// File: rtl/pwm8_demod_sync_bit.sv
// sync_bit
//   Multi-flop synchronizer for one asynchronous bit.
//   clk  in   system clock
//   rst  in   synchronous active-high reset, clears the chain
//   d    in   asynchronous input
//   q    out  synchronized output, STAGES clocks behind d
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pwm8_demod.sv
// pwm8_demod
//   Recovers a WIDTH-bit level from a 1-bit PWM stream by counting high samples
//   over back-to-back 2^WIDTH-cycle windows. One word is published per window;
//   locked reports that consecutive windows agree within TOL.
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   sin        in   asynchronous PWM input
//   out_data   out  last recovered level, held between updates
//   out_valid  out  one-cycle strobe when out_data is updated
//   locked     out  level stable within TOL for LOCK_COUNT windows
//
//   state      | meaning
//   ST_WARMUP  | first window after reset, discarded (sync chain filling)
//   ST_MEASURE | every window end publishes a level and updates lock tracking
module pwm8_demod
    import pwm8_demod_pkg::*;
#(
    parameter int WIDTH       = PWM_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_COUNT  = 2,
    parameter int TOL         = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             locked
);

    localparam int MW = $clog2(LOCK_COUNT);
    localparam logic [MW-1:0] LOCK_MAX = MW'(LOCK_COUNT - 1);

    logic             s;
    logic [WIDTH-1:0] win_cnt;
    logic [WIDTH:0]   hi_cnt;
    logic [WIDTH:0]   total;
    logic [WIDTH-1:0] level;
    logic [WIDTH:0]   diff;
    logic             in_tol;
    logic             win_last;
    logic [MW-1:0]    match_cnt;
    logic [MW-1:0]    match_next;
    state_t           state;

    sync_bit #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (sin),
        .q  (s)
    );

    assign win_last = &win_cnt;

    // Total includes the current sample, so a full-high window reaches 2^WIDTH,
    // which does not fit in WIDTH bits and is clamped to all-ones.
    assign total = hi_cnt + {{WIDTH{1'b0}}, s};
    assign level = total[WIDTH] ? {WIDTH{1'b1}} : total[WIDTH-1:0];

    always_comb begin
        diff = '0;
        if (level >= out_data) begin
            diff = {1'b0, level} - {1'b0, out_data};
        end else begin
            diff = {1'b0, out_data} - {1'b0, level};
        end
    end

    assign in_tol     = (diff <= (WIDTH+1)'(TOL));
    assign match_next = !in_tol ? '0 :
                        (match_cnt == LOCK_MAX) ? match_cnt : match_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt <= '0;
            hi_cnt  <= '0;
        end else begin
            win_cnt <= win_cnt + 1'b1;
            hi_cnt  <= win_last ? '0 : total;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_WARMUP;
            out_data  <= '0;
            out_valid <= 1'b0;
            locked    <= 1'b0;
            match_cnt <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                ST_WARMUP: begin
                    if (win_last) begin
                        state <= ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (win_last) begin
                        out_data  <= level;
                        out_valid <= 1'b1;
                        match_cnt <= match_next;
                        locked    <= (match_next == LOCK_MAX);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm8_demod.sv
// tb_pwm8_demod
//   Directed bench for pwm8_demod: constant, PWM, toggling and ramping sources,
//   plus mid-window reset. A second instance with TOL=0 shares all inputs.
module tb_pwm8_demod;

    logic       clk;
    logic       rst;
    logic       sin;
    logic [7:0] out_data;
    logic       out_valid;
    logic       locked;
    logic [7:0] out_data0;
    logic       out_valid0;
    logic       locked0;

    int n_cmp;
    int n_fail;
    int cyc;
    int mode;   // 0 constant, 1 PWM DAC model, 2 toggle
    int fc;
    int lvl;
    int tgt;
    int at;
    int prev_at;
    int prev;
    int drops;
    int d;

    pwm8_demod #(.TOL(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .sin      (sin),
        .out_data (out_data),
        .out_valid(out_valid),
        .locked   (locked)
    );

    pwm8_demod #(.TOL(0)) dut0 (
        .clk      (clk),
        .rst      (rst),
        .sin      (sin),
        .out_data (out_data0),
        .out_valid(out_valid0),
        .locked   (locked0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: sample point is 1 time unit after the edge; then drive sin.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        case (mode)
            1: begin
                if (fc == 0 && lvl < tgt) lvl++;
                sin = (fc < lvl);
                fc  = (fc + 1) % 256;
            end
            2: sin = ~sin;
            default: ;
        endcase
    endtask

    task automatic wait_strobe(input int budget, output int when);
        when = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (out_valid) begin
                when = cyc;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (4) step();
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; cyc = 0;
        rst = 1'b1; sin = 1'b0; mode = 0; fc = 0; lvl = 0; tgt = 0;

        // 1: constant low
        do_reset();
        check("rst_out_data", out_data, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_locked", locked, 0);
        wait_strobe(600, at);
        check("t1_strobe1_cycle", at, 512);
        check("t1_strobe1_data", out_data, 0);
        check("t1_strobe1_locked", locked, 1);
        step();
        check("t1_strobe_width", out_valid, 0);
        wait_strobe(300, at);
        check("t1_strobe2_cycle", at, 768);
        check("t1_strobe2_data", out_data, 0);
        check("t1_strobe2_locked", locked, 1);

        // 2: PWM at 100, random phase
        mode = 1; lvl = 100; tgt = 100; fc = int'($urandom_range(0, 255));
        do_reset();
        wait_strobe(600, at);
        check("t2_strobe1_cycle", at, 512);
        check("t2_strobe1_data", out_data, 100);
        check("t2_strobe1_locked", locked, 0);
        wait_strobe(300, at);
        check("t2_strobe2_cycle", at, 768);
        check("t2_strobe2_data", out_data, 100);
        check("t2_strobe2_locked", locked, 1);
        wait_strobe(300, at);
        check("t2_strobe3_data", out_data, 100);

        // 3: constant high saturates
        mode = 0; sin = 1'b1;
        do_reset();
        wait_strobe(600, at);
        check("t3_strobe1_data", out_data, 255);
        check("t3_strobe1_locked", locked, 0);
        wait_strobe(300, at);
        check("t3_strobe2_data", out_data, 255);
        check("t3_strobe2_locked", locked, 1);

        // 4: toggle every cycle
        mode = 2;
        do_reset();
        wait_strobe(600, at);
        check("t4_strobe1_data", out_data, 128);
        wait_strobe(300, at);
        check("t4_strobe2_data", out_data, 128);
        check("t4_strobe2_locked", locked, 1);

        // 5: ramp 100 -> 110, one step per frame
        mode = 1; lvl = 100; tgt = 100; fc = 37;
        do_reset();
        wait_strobe(600, at);
        wait_strobe(300, at);
        check("t5_pre_data", out_data, 100);
        check("t5_pre_locked", locked, 1);
        check("t5_pre_locked_tol0", locked0, 1);
        tgt = 110;
        prev = 100; prev_at = at; drops = 0;
        for (int k = 0; k < 14; k++) begin
            wait_strobe(300, at);
            check("t5_period", at - prev_at, 256);
            d = (int'(out_data) > prev) ? int'(out_data) - prev : prev - int'(out_data);
            check("t5_step_le1", (d <= 1) ? 1 : 0, 1);
            check("t5_locked", locked, 1);
            if (!locked0) drops++;
            prev = int'(out_data);
            prev_at = at;
        end
        check("t5_final_data", out_data, 110);
        check("t5_tol0_dropped", (drops > 0) ? 1 : 0, 1);
        check("t5_tol0_relocked", locked0, 1);

        // 6: reset at win_cnt=128 of a locked stream
        repeat (128) step();
        rst = 1'b1;
        step();
        check("t6_rst_data", out_data, 0);
        check("t6_rst_locked", locked, 0);
        check("t6_rst_valid", out_valid, 0);
        rst = 1'b0;
        cyc = 0;
        wait_strobe(600, at);
        check("t6_strobe_cycle", at, 512);
        check("t6_strobe_data", out_data, 110);
        check("t6_strobe_locked", locked, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
